// File: rtl/scan_select_gen_pkg.sv
// Shared types and constants for the digit scanner: FSM state encoding,
// decoder enable patterns and the nibble selection helper.
package scan_select_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // {G,G2A,G2B} patterns for the 74LS138
  localparam logic [2:0] DEC_OFF = 3'b011;
  localparam logic [2:0] DEC_ON  = 3'b100;

  function automatic logic [3:0] nibble_of(input logic [31:0] word, input logic [2:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/scan_select_gen_pick.sv
// Rotating priority search: first set mask bit after cur (cur+1 .. cur+8, mod 8).
// With cur=7 this yields the lowest set bit.
module mask_rotate_pick (
  input  logic [2:0] cur,
  input  logic [7:0] mask,
  output logic [2:0] nxt,
  output logic       none
);

  logic [2:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    nxt = cur;
    idx = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (mask[idx]) begin
        nxt = idx;
      end else begin
        nxt = nxt;
      end
    end
  end

  assign none = (mask == 8'h00);

endmodule

// File: rtl/scan_select_gen.sv
// Time-multiplexed digit scanner driving a 74LS138 decoder: shows each enabled
// digit for one tick, optionally followed by blank ticks with the decoder off.
module scan_select_gen
  import scan_select_gen_pkg::*;
#(
  parameter  int DIV         = 100000,
  parameter  int BLANK_TICKS = 1,
  localparam int CNT_W       = $clog2(DIV)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  digit_mask,
  input  logic [31:0] data,
  output logic [2:0]  sel,
  output logic        G,
  output logic        G2A,
  output logic        G2B,
  output logic [3:0]  hex,
  output logic        tick
);

  localparam int BW = (BLANK_TICKS < 1) ? 1 : $clog2(BLANK_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [BW-1:0]    BT_LAST = BW'((BLANK_TICKS > 0) ? (BLANK_TICKS - 1) : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       dec_q, dec_d;
  logic [3:0]       hex_q, hex_d;
  logic             tick_q, tick_d;

  logic [2:0] adv_sel_s, first_sel_s;
  logic       adv_none_s, first_none_s;
  logic       wrap_s;
  state_e     adv_state_s;

  mask_rotate_pick u_pick_adv (
    .cur  (sel_q),
    .mask (digit_mask),
    .nxt  (adv_sel_s),
    .none (adv_none_s)
  );

  mask_rotate_pick u_pick_first (
    .cur  (3'd7),
    .mask (digit_mask),
    .nxt  (first_sel_s),
    .none (first_none_s)
  );

  assign wrap_s      = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);
  assign adv_state_s = adv_none_s ? ST_IDLE : ST_SHOW;

  // Next-state logic; an empty mask at an advance parks the scanner with sel held.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && !first_none_s) begin
          state_d = ST_SHOW;
          sel_d   = first_sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (wrap_s) begin
          if (BLANK_TICKS > 0) begin
            state_d = ST_BLANK;
            bcnt_d  = {BW{1'b0}};
          end else begin
            state_d = adv_state_s;
            sel_d   = adv_sel_s;
          end
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_BLANK: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (wrap_s) begin
          if (bcnt_q == BT_LAST) begin
            state_d = adv_state_s;
            sel_d   = adv_sel_s;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end else begin
          state_d = ST_BLANK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (wrap_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    tick_d = wrap_s;
    dec_d  = (state_d == ST_SHOW) ? DEC_ON : DEC_OFF;
    hex_d  = nibble_of(data, sel_d);
  end

  // State and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      bcnt_q  <= {BW{1'b0}};
      sel_q   <= 3'd0;
      dec_q   <= DEC_OFF;
      hex_q   <= 4'h0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      sel_q   <= sel_d;
      dec_q   <= dec_d;
      hex_q   <= hex_d;
      tick_q  <= tick_d;
    end
  end

  assign sel             = sel_q;
  assign {G, G2A, G2B}   = dec_q;
  assign hex             = hex_q;
  assign tick            = tick_q;

endmodule
